// File: rtl/adc_sample_pacer.sv
// Paced sample feeder: buffers a bursty sample stream in a small FIFO and re-emits
// one sample every DIV clocks. Optional counters: define ADC_SAMPLE_PACER_STATS_EN.
module adc_sample_pacer #(
  parameter int DATA_W        = 24,
  parameter int DIV           = 10,
  parameter int FIFO_DEPTH    = 8,
  parameter int PRIME_LEVEL   = 4,
  parameter int IN_OFFSET_BIN = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          flush,
  input  logic [DATA_W-1:0]             s_data,
  input  logic                          s_last,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [DATA_W-1:0]             m_data,
  output logic                          m_valid,
  output logic                          m_last,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
`ifdef ADC_SAMPLE_PACER_STATS_EN
  ,
  output logic [15:0]                   underrun_cnt,
  output logic [31:0]                   sample_cnt
`endif
);

  // state | meaning
  // IDLE  | pacing stopped, counter parked at 0, FIFO may still fill
  // PRIME | waiting for PRIME_LEVEL entries or a buffered last marker
  // RUN   | counter free-runs, one pop attempt per DIV clocks

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0]     CNT_TC    = CW'(DIV - 1);
  localparam logic [LW-1:0]     LVL_FULL  = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0]     LVL_PRIME = LW'(PRIME_LEVEL);
  localparam logic [DATA_W-1:0] MSB_MASK  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] IN_MASK   = (IN_OFFSET_BIN != 0) ? MSB_MASK : '0;

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  logic [DATA_W:0] mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level, level_nxt;
  logic [LW-1:0]   last_cnt, last_cnt_nxt;
  logic            full_q;
  state_t          state;
  logic [CW-1:0]   cnt;

  logic            push, pop, tick, starve, empty;
  logic            push_last, pop_last;
  logic [DATA_W:0] wr_word, rd_word;

  always_comb begin
    empty     = (level == '0);
    tick      = (state == RUN) && (cnt == CNT_TC);
    push      = s_valid && !full_q && !flush;
    pop       = tick && !empty && !flush;
    starve    = tick && empty && !flush;
    wr_word   = {s_last, s_data ^ IN_MASK};
    rd_word   = mem[rd_ptr];
    push_last = push && s_last;
    pop_last  = pop && rd_word[DATA_W];
  end

  // Occupancy and buffered-last count move together with push/pop.
  always_comb begin
    level_nxt = level;
    if (push && !pop)
      level_nxt = level + LW'(1);
    else if (pop && !push)
      level_nxt = level - LW'(1);

    last_cnt_nxt = last_cnt;
    if (push_last && !pop_last)
      last_cnt_nxt = last_cnt + LW'(1);
    else if (pop_last && !push_last)
      last_cnt_nxt = last_cnt - LW'(1);
  end

  assign s_ready    = !full_q;
  assign fifo_level = level;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wr_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      last_cnt <= '0;
      full_q   <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      last_cnt <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      level    <= level_nxt;
      last_cnt <= last_cnt_nxt;
      full_q   <= (level_nxt == LVL_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      m_data   <= '0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      underrun <= 1'b0;
      busy     <= 1'b0;
`ifdef ADC_SAMPLE_PACER_STATS_EN
      underrun_cnt <= '0;
      sample_cnt   <= '0;
`endif
    end else begin
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      underrun <= 1'b0;
      if (flush) begin
        state <= IDLE;
        cnt   <= '0;
        busy  <= 1'b0;
`ifdef ADC_SAMPLE_PACER_STATS_EN
        underrun_cnt <= '0;
        sample_cnt   <= '0;
`endif
      end else begin
        if (pop) begin
          m_valid <= 1'b1;
          m_data  <= rd_word[DATA_W-1:0];
          m_last  <= rd_word[DATA_W];
        end
        if (starve)
          underrun <= 1'b1;
`ifdef ADC_SAMPLE_PACER_STATS_EN
        if (pop)
          sample_cnt <= sample_cnt + 32'd1;
        if (starve && (underrun_cnt != 16'hFFFF))
          underrun_cnt <= underrun_cnt + 16'd1;
`endif
        case (state)
          IDLE: begin
            cnt <= '0;
            if (enable) begin
              state <= PRIME;
              busy  <= 1'b1;
            end
          end
          PRIME: begin
            if (!enable) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else if ((level >= LVL_PRIME) || (last_cnt != '0)) begin
              state <= RUN;
              cnt   <= '0;
            end
          end
          RUN: begin
            // A tick that coincides with enable falling still pops above.
            if (pop_last || !enable) begin
              state <= IDLE;
              cnt   <= '0;
              busy  <= 1'b0;
            end else if (tick) begin
              cnt <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_sample_pacer.sv
// Self-checking bench for adc_sample_pacer: queue-based reference model plus
// directed burst/starvation/flush/reset scenarios and a randomized stream.
module tb_adc_sample_pacer;
  localparam int DATA_W = 24;
  localparam int DIV    = 10;
  localparam int DEPTH  = 8;
  localparam int PRIME  = 4;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic              enable = 0, flush = 0, s_last = 0, s_valid = 0;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_ready, m_valid, m_last, underrun, busy;
  logic [DATA_W-1:0] m_data;
  logic [LW-1:0]     fifo_level;

  logic              ob_enable = 0, ob_flush = 0, ob_s_last = 0, ob_s_valid = 0;
  logic [DATA_W-1:0] ob_s_data = '0;
  logic              ob_s_ready, ob_m_valid, ob_m_last, ob_underrun, ob_busy;
  logic [DATA_W-1:0] ob_m_data;
  logic [LW-1:0]     ob_fifo_level;
`ifdef ADC_SAMPLE_PACER_STATS_EN
  logic [15:0] underrun_cnt, ob_underrun_cnt;
  logic [31:0] sample_cnt, ob_sample_cnt;
`endif

  adc_sample_pacer #(.DATA_W(DATA_W), .DIV(DIV), .FIFO_DEPTH(DEPTH),
                     .PRIME_LEVEL(PRIME), .IN_OFFSET_BIN(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
    .s_data(s_data), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .underrun(underrun),
    .fifo_level(fifo_level), .busy(busy)
`ifdef ADC_SAMPLE_PACER_STATS_EN
    , .underrun_cnt(underrun_cnt), .sample_cnt(sample_cnt)
`endif
  );

  adc_sample_pacer #(.DATA_W(DATA_W), .DIV(DIV), .FIFO_DEPTH(DEPTH),
                     .PRIME_LEVEL(PRIME), .IN_OFFSET_BIN(1)) u_ob (
    .clk(clk), .rst_n(rst_n), .enable(ob_enable), .flush(ob_flush),
    .s_data(ob_s_data), .s_last(ob_s_last), .s_valid(ob_s_valid), .s_ready(ob_s_ready),
    .m_data(ob_m_data), .m_valid(ob_m_valid), .m_last(ob_m_last), .underrun(ob_underrun),
    .fifo_level(ob_fifo_level), .busy(ob_busy)
`ifdef ADC_SAMPLE_PACER_STATS_EN
    , .underrun_cnt(ob_underrun_cnt), .sample_cnt(ob_sample_cnt)
`endif
  );

  int n_vec = 0, n_err = 0;
  int cyc = 0, last_evt = -1, busy_rise = -1;
  int n_strobe = 0, n_under = 0;
  logic busy_d = 0, seen_full = 0;
  logic [DATA_W-1:0] hold = '0;
  logic [DATA_W:0] q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock of the main DUT: advance the model, then compare at posedge+1.
  task automatic tick();
    logic push_now, flush_now;
    logic [DATA_W:0] w, e;
    int pre;
    push_now  = s_valid && (q.size() != DEPTH) && !flush;
    flush_now = flush;
    w   = {s_last, s_data};
    pre = q.size();
    @(posedge clk);
    #1;
    cyc++;
    if (flush_now) begin
      q.delete();
      last_evt = -1;
      chk("flush_m_valid", m_valid, 0);
      chk("flush_underrun", underrun, 0);
    end else begin
      if (m_valid) begin
        n_strobe++;
        chk("pop_nonempty", pre != 0, 1);
        if (pre != 0) begin
          e = q.pop_front();
          hold = e[DATA_W-1:0];
          chk("m_data", m_data, e[DATA_W-1:0]);
          chk("m_last", m_last, e[DATA_W]);
        end
      end else begin
        chk("m_last_idle", m_last, 0);
        chk("m_data_hold", m_data, hold);
      end
      if (underrun) begin
        n_under++;
        chk("underrun_when_empty", pre, 0);
      end
      if (push_now) q.push_back(w);
      if (m_valid || underrun) begin
        if (last_evt >= 0) chk("tick_spacing", cyc - last_evt, DIV);
        last_evt = cyc;
      end
    end
    chk("fifo_level", fifo_level, q.size());
    chk("s_ready", s_ready, q.size() != DEPTH);
    if (q.size() == DEPTH) seen_full = 1;
    if (!busy) last_evt = -1;
    if (busy && !busy_d) busy_rise = cyc;
    busy_d = busy;
  endtask

  task automatic push_one(input logic [DATA_W-1:0] d, input logic l);
    logic done;
    int g;
    done = 0;
    g = 0;
    s_valid = 1; s_data = d; s_last = l;
    while (!done && g < 300) begin
      done = (q.size() != DEPTH);
      tick();
      g++;
    end
    s_valid = 0; s_last = 0;
    chk("push_accepted", done, 1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int guard, idx, k;
  logic acc;
  logic [DATA_W-1:0] ob_in [3];
  logic [DATA_W-1:0] ob_exp [3];
  logic [DATA_W-1:0] ob_got [3];

  initial begin
    ob_in[0] = 24'h800000; ob_in[1] = 24'h000000; ob_in[2] = 24'hFFFFFF;
    ob_exp[0] = 24'h000000; ob_exp[1] = 24'h800000; ob_exp[2] = 24'h7FFFFF;

    #2 rst_n = 0;
    #1;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_fifo_level", fifo_level, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    // Paced burst of 1..16, last marker on the final sample.
    enable = 1; seen_full = 0; n_strobe = 0; n_under = 0;
    idx = 1; guard = 0;
    s_valid = 1;
    while (idx <= 16 && guard < 500) begin
      s_data = DATA_W'(idx);
      s_last = (idx == 16);
      acc = (q.size() != DEPTH);
      tick();
      if (acc) idx++;
      guard++;
    end
    s_valid = 0; s_last = 0;
    guard = 0;
    while (n_strobe < 16 && guard < 400) begin tick(); guard++; end
    chk("burst_strobes", n_strobe, 16);
    chk("burst_underruns", n_under, 0);
    chk("burst_full_seen", seen_full, 1);

    // Preload in IDLE, then starvation.
    enable = 0;
    idle_cycles(2);
    for (int i = 0; i < PRIME; i++) push_one(DATA_W'($urandom), 1'b0);
    chk("preload_level", fifo_level, PRIME);
    chk("preload_idle", busy, 0);
    enable = 1; n_strobe = 0; n_under = 0; busy_rise = -1; guard = 0;
    while (n_strobe < 1 && guard < 100) begin tick(); guard++; end
    chk("first_latency", cyc - busy_rise, DIV + 1);
    guard = 0;
    while (n_under < 3 && guard < 200) begin tick(); guard++; end
    chk("starve_strobes", n_strobe, PRIME);
    chk("starve_underruns", n_under, 3);
    push_one(DATA_W'($urandom), 1'b0);
    guard = 0;
    while (n_strobe < PRIME + 1 && n_under < 4 && guard < 100) begin tick(); guard++; end
    chk("refill_emitted", n_strobe, PRIME + 1);
    chk("refill_no_underrun", n_under, 3);

    // Flush mid-RUN with five entries buffered.
    for (int i = 0; i < 5; i++) push_one(DATA_W'($urandom), 1'b0);
    chk("pre_flush_level", fifo_level, 5);
    flush = 1;
    tick();
    flush = 0;
    chk("flush_level", fifo_level, 0);
    chk("flush_busy", busy, 0);
    tick();
    chk("reprime_busy", busy, 1);
    n_strobe = 0; n_under = 0;
    idle_cycles(40);
    chk("no_output_unprimed", n_strobe + n_under, 0);

    // Short stream closed by a last marker, below the prime level.
    push_one(24'h00A001, 1'b0);
    push_one(24'h00A002, 1'b0);
    push_one(24'h00A003, 1'b1);
    guard = 0;
    while (n_strobe < 3 && guard < 100) begin tick(); guard++; end
    chk("last_strobes", n_strobe, 3);
    chk("last_m_last", m_last, 1);
    chk("last_busy_drop", busy, 0);

    // Asynchronous reset in the middle of RUN, right after a strobe.
    for (int i = 0; i < PRIME; i++) push_one(DATA_W'($urandom), 1'b0);
    n_strobe = 0; guard = 0;
    while (n_strobe < 1 && guard < 100) begin tick(); guard++; end
    chk("pre_reset_valid", m_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_m_valid", m_valid, 0);
    chk("arst_m_data", m_data, 0);
    chk("arst_fifo_level", fifo_level, 0);
    chk("arst_busy", busy, 0);
    chk("arst_s_ready", s_ready, 1);
    q.delete(); hold = '0; last_evt = -1; busy_d = 0;
    enable = 0;
    @(negedge clk);
    rst_n = 1;

    // Randomized stream with random enable and occasional flush.
    for (int i = 0; i < 2500; i++) begin
      s_valid = ($urandom_range(0, 99) < 40);
      s_data  = DATA_W'($urandom);
      s_last  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      flush   = ($urandom_range(0, 299) == 0);
      tick();
    end
    flush = 0; s_valid = 0; s_last = 0; enable = 1;
    push_one(DATA_W'($urandom), 1'b1);
    guard = 0;
    while (q.size() != 0 && guard < 600) begin tick(); guard++; end
    chk("drain_empty", q.size(), 0);

    // Offset-binary instance: MSB inverted on write.
    for (int i = 0; i < 3; i++) begin
      ob_s_valid = 1; ob_s_data = ob_in[i]; ob_s_last = (i == 2);
      tick();
    end
    ob_s_valid = 0; ob_s_last = 0; ob_enable = 1;
    k = 0; guard = 0;
    while (k < 3 && guard < 100) begin
      tick();
      if (ob_m_valid) begin ob_got[k] = ob_m_data; k++; end
      guard++;
    end
    chk("ob_count", k, 3);
    for (int i = 0; i < 3; i++) chk("ob_data", ob_got[i], ob_exp[i]);

`ifdef ADC_SAMPLE_PACER_STATS_EN
    enable = 0; flush = 1;
    tick();
    flush = 0;
    for (int i = 0; i < PRIME; i++) push_one(DATA_W'($urandom), 1'b0);
    enable = 1; n_strobe = 0; n_under = 0; guard = 0;
    while (n_under < 5 && guard < 200) begin tick(); guard++; end
    enable = 0;
    chk("stats_sample_cnt", sample_cnt, n_strobe);
    chk("stats_samples_exp", sample_cnt, PRIME);
    chk("stats_underrun_cnt", underrun_cnt, 5);
    flush = 1;
    tick();
    flush = 0;
    chk("stats_flush_sample", sample_cnt, 0);
    chk("stats_flush_underrun", underrun_cnt, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
